// File: rtl/ifetch_queue_if.sv
`default_nettype none
// ============================================================================
// ifetch_queue_if : redirect, instruction-memory and datapath-side bundle
// Revision: 1.0
// ============================================================================
interface ifetch_queue_if;
  logic        redirect_valid;
  logic [63:0] redirect_pc;
  logic        imem_req_valid;
  logic [63:0] imem_req_addr;
  logic        imem_req_ready;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        inst_valid;
  logic [31:0] inst_data;
  logic [63:0] inst_pc;
  logic        inst_ready;

  modport master (
    input  redirect_valid, redirect_pc, imem_req_ready, imem_resp_valid,
           imem_resp_data, inst_ready,
    output imem_req_valid, imem_req_addr, inst_valid, inst_data, inst_pc
  );

  modport slave (
    output redirect_valid, redirect_pc, imem_req_ready, imem_resp_valid,
           imem_resp_data, inst_ready,
    input  imem_req_valid, imem_req_addr, inst_valid, inst_data, inst_pc
  );
endinterface
`default_nettype wire

// File: rtl/ifetch_queue.sv
`default_nettype none
// ============================================================================
// ifetch_queue : credit-based instruction fetcher with in-order response queue
// Revision: 1.0
// ============================================================================
module ifetch_queue #(
  parameter logic [63:0] RESET_PC = 64'h0,
  parameter int unsigned DEPTH    = 4
) (
  input  wire logic      clk,
  input  wire logic      rst,
  ifetch_queue_if.master bus
);
  localparam int unsigned     c_AW      = $clog2(DEPTH);
  localparam int unsigned     c_CW      = c_AW + 1;
  localparam logic [31:0]     c_NOP     = 32'h0000_0013;
  localparam logic [c_CW:0]   c_CREDITS = DEPTH[c_CW:0];
  localparam logic [c_CW-1:0] c_CNT_ONE = 1;
  localparam logic [c_AW-1:0] c_PTR_ONE = 1;

  typedef enum logic [0:0] {
    ST_FETCH = 1'b0,
    ST_DRAIN = 1'b1
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [63:0]     r_fetch_pc;
  logic [63:0]     r_resp_pc;
  logic [c_CW-1:0] r_outstanding;
  logic [c_CW-1:0] r_drop_cnt;
  logic [c_CW-1:0] r_count;
  logic [c_AW-1:0] r_wptr;
  logic [c_AW-1:0] r_rptr;
  logic [31:0]     r_q_data [DEPTH];
  logic [63:0]     r_q_pc   [DEPTH];

  logic            w_req_valid;
  logic            w_req_hs;
  logic            w_resp;
  logic            w_push;
  logic            w_pop;
  logic            w_credit_ok;
  logic            w_inst_valid;
  logic [c_CW-1:0] w_out_after_resp;
  logic [c_CW-1:0] w_drop_nxt;
  logic [63:0]     w_redirect_pc;
  logic            w_unused_pc_lsb;

  assign w_redirect_pc    = {bus.redirect_pc[63:2], 2'b00};
  assign w_unused_pc_lsb  = ^bus.redirect_pc[1:0];
  assign w_resp           = bus.imem_resp_valid && (r_outstanding != '0);
  assign w_out_after_resp = r_outstanding - {{(c_CW-1){1'b0}}, w_resp};
  // Every outstanding request owns a queue slot, so responses never overflow.
  assign w_credit_ok      = ({1'b0, r_count} + {1'b0, r_outstanding}) < c_CREDITS;

  assign w_req_hs = bus.imem_req_valid && bus.imem_req_ready;
  assign w_push   = (r_state == ST_FETCH) && w_resp && !bus.redirect_valid;
  assign w_pop    = (r_count != '0) && bus.inst_ready && !bus.redirect_valid;

  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_FETCH;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_req_valid = 1'b0;
    w_drop_nxt  = r_drop_cnt;
    if (bus.redirect_valid) begin
      // A response landing with the redirect is already discarded, so not counted.
      w_drop_nxt  = w_out_after_resp;
      w_state_nxt = (w_out_after_resp != '0) ? ST_DRAIN : ST_FETCH;
    end else begin
      case (r_state)
        ST_FETCH: w_req_valid = w_credit_ok;
        ST_DRAIN: begin
          if (w_resp) w_drop_nxt = r_drop_cnt - c_CNT_ONE;
          if (w_drop_nxt == '0) w_state_nxt = ST_FETCH;
        end
        default: w_state_nxt = ST_FETCH;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_fetch_pc    <= RESET_PC;
      r_resp_pc     <= RESET_PC;
      r_outstanding <= '0;
      r_drop_cnt    <= '0;
      r_count       <= '0;
      r_wptr        <= '0;
      r_rptr        <= '0;
    end else begin
      r_outstanding <= r_outstanding + {{(c_CW-1){1'b0}}, w_req_hs}
                                     - {{(c_CW-1){1'b0}}, w_resp};
      r_drop_cnt    <= w_drop_nxt;
      if (bus.redirect_valid) begin
        r_fetch_pc <= w_redirect_pc;
        r_resp_pc  <= w_redirect_pc;
        r_count    <= '0;
        r_wptr     <= '0;
        r_rptr     <= '0;
      end else begin
        if (w_req_hs) r_fetch_pc <= r_fetch_pc + 64'd4;
        // Requests are sequential between redirects, so one running PC tags responses.
        if (w_push) begin
          r_resp_pc <= r_resp_pc + 64'd4;
          r_wptr    <= r_wptr + c_PTR_ONE;
        end
        if (w_pop) r_rptr <= r_rptr + c_PTR_ONE;
        case ({w_push, w_pop})
          2'b10:   r_count <= r_count + c_CNT_ONE;
          2'b01:   r_count <= r_count - c_CNT_ONE;
          default: r_count <= r_count;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_q_data[r_wptr] <= bus.imem_resp_data;
      r_q_pc[r_wptr]   <= r_resp_pc;
    end
  end

  assign w_inst_valid       = !rst && (r_count != '0);
  assign bus.inst_valid     = w_inst_valid;
  assign bus.inst_data      = w_inst_valid ? r_q_data[r_rptr] : c_NOP;
  assign bus.inst_pc        = w_inst_valid ? r_q_pc[r_rptr] : 64'h0;
  assign bus.imem_req_valid = w_req_valid && !rst;
  assign bus.imem_req_addr  = r_fetch_pc;
endmodule
`default_nettype wire
